// File: rtl/job_dispatch_pkg.sv
// Shared state encoding and widths for the job dispatch scheduler and its arbiter.
package job_dispatch_pkg;

  localparam int NUM_CHIPS  = 8;
  localparam int CHIP_IDX_W = 3;
  localparam int WDOG_W     = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_DONE,
    RELEASE,
    FAULT
  } dispatchState_t;

endpackage

// File: rtl/job_dispatch_rr_arbiter8.sv
// Round-robin pick among eight requesters, searching upward from lastGrant+1; purely
// combinational (zero latency), no backpressure: the caller decides when a grant is taken.
module rr_arbiter8
  import job_dispatch_pkg::*;
(
  input  logic [NUM_CHIPS-1:0]  request,
  input  logic [CHIP_IDX_W-1:0] lastGrant,
  output logic                  valid,
  output logic [CHIP_IDX_W-1:0] grant
);

  logic [CHIP_IDX_W-1:0] base;
  logic [NUM_CHIPS-1:0]  rotated;
  logic [CHIP_IDX_W-1:0] offset;

  assign base = lastGrant + CHIP_IDX_W'(1);

  // Rotate so the first candidate sits at bit 0; the 3-bit index sum wraps mod 8.
  always_comb begin
    rotated = '0;
    for (int i = 0; i < NUM_CHIPS; i++) begin
      rotated[i] = request[base + CHIP_IDX_W'(i)];
    end
  end

  always_comb begin
    offset = '0;
    for (int i = NUM_CHIPS - 1; i >= 0; i--) begin
      if (rotated[i]) offset = CHIP_IDX_W'(i);
    end
  end

  assign valid = |request;
  assign grant = base + offset;

endmodule

// File: rtl/job_dispatch_scheduler.sv
// Round-robin sequencer of the issuance engine over 8 chips; grant to IssueStart 1 cycle, done to JobAck 1 cycle.
// Holds off new grants while an issuance is in flight or done lingers; JOB_DISPATCH_TIMEOUT_EN adds the watchdog.
module job_dispatch_scheduler
  import job_dispatch_pkg::*;
#(
  parameter int NUM_CHIPS      = 8,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                  SysClock,
  input  logic                  SysReset_N,
  input  logic                  DispatchEnable,
  input  logic [NUM_CHIPS-1:0]  ChipEnableMask,
  input  logic [NUM_CHIPS-1:0]  JobPending,
  output logic                  IssueStart,
  output logic [CHIP_IDX_W-1:0] IssueChipIndex,
  output logic                  IssueJobIndex,
  input  logic                  IssueDone,
  output logic [NUM_CHIPS-1:0]  JobAck,
  output logic [NUM_CHIPS-1:0]  SlotSel,
  output logic                  Busy,
  output logic                  TimeoutFault,
  input  logic                  FaultClear
);

  dispatchState_t        state, nextState;
  logic [CHIP_IDX_W-1:0] lastChip;
  logic [CHIP_IDX_W-1:0] arbGrant;
  logic                  arbValid;
  logic                  wdogExpired;
  logic [NUM_CHIPS-1:0]  eligible;

  assign eligible = DispatchEnable ? (JobPending & ChipEnableMask) : '0;

  rr_arbiter8 uArbiter (
    .request  (eligible),
    .lastGrant(lastChip),
    .valid    (arbValid),
    .grant    (arbGrant)
  );

  always_ff @(posedge SysClock or negedge SysReset_N) begin
    if (!SysReset_N) state <= IDLE;
    else             state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:      if (arbValid) nextState = START;
      START:     nextState = WAIT_DONE;
      WAIT_DONE: begin
        if (IssueDone)        nextState = RELEASE;
        else if (wdogExpired) nextState = FAULT;
      end
      // A done level still high from the last job must not count for the next one.
      RELEASE:   if (!IssueDone) nextState = IDLE;
      FAULT:     if (FaultClear) nextState = RELEASE;
      default:   nextState = IDLE;
    endcase
  end

  assign IssueStart = (state == START);
  assign Busy       = (state != IDLE);

  always_ff @(posedge SysClock or negedge SysReset_N) begin
    if (!SysReset_N) begin
      IssueChipIndex <= '0;
      IssueJobIndex  <= 1'b0;
      JobAck         <= '0;
      SlotSel        <= '0;
      lastChip       <= CHIP_IDX_W'(NUM_CHIPS - 1);
    end else begin
      JobAck <= '0;
      if (state == IDLE && arbValid) begin
        IssueChipIndex <= arbGrant;
        IssueJobIndex  <= SlotSel[arbGrant];
      end
      if (state == WAIT_DONE && IssueDone) begin
        JobAck                  <= NUM_CHIPS'(1) << IssueChipIndex;
        SlotSel[IssueChipIndex] <= ~SlotSel[IssueChipIndex];
        lastChip                <= IssueChipIndex;
      end
    end
  end

`ifdef JOB_DISPATCH_TIMEOUT_EN
  localparam logic [WDOG_W-1:0] WdogLimit = WDOG_W'(TIMEOUT_CYCLES - 1);

  logic [WDOG_W-1:0] wdogCount;
  logic              faultFlag;

  assign wdogExpired = (state == WAIT_DONE) && !IssueDone && (wdogCount == WdogLimit);

  always_ff @(posedge SysClock or negedge SysReset_N) begin
    if (!SysReset_N) begin
      wdogCount <= '0;
      faultFlag <= 1'b0;
    end else begin
      if (state == START) begin
        wdogCount <= '0;
      end else if (state == WAIT_DONE && !IssueDone && !wdogExpired) begin
        wdogCount <= wdogCount + WDOG_W'(1);
      end
      if (wdogExpired) begin
        faultFlag <= 1'b1;
      end else if (state == FAULT && FaultClear) begin
        faultFlag <= 1'b0;
      end
    end
  end

  assign TimeoutFault = faultFlag;
`else
  logic [WDOG_W-1:0] unusedTimeoutCycles;

  assign unusedTimeoutCycles = WDOG_W'(TIMEOUT_CYCLES);
  assign wdogExpired         = 1'b0;
  assign TimeoutFault        = 1'b0;
`endif

endmodule

// File: tb/tb_job_dispatch_scheduler.sv
// Randomized and directed bench for job_dispatch_scheduler against a queue-free arbitration model.
module tb_job_dispatch_scheduler;

  logic       SysClock = 1'b0;
  logic       SysReset_N;
  logic       DispatchEnable;
  logic [7:0] ChipEnableMask;
  logic [7:0] JobPending;
  logic       IssueStart;
  logic [2:0] IssueChipIndex;
  logic       IssueJobIndex;
  logic       IssueDone;
  logic [7:0] JobAck;
  logic [7:0] SlotSel;
  logic       Busy;
  logic       TimeoutFault;
  logic       FaultClear;

  int         nChecks = 0;
  int         nErrors = 0;

  // Reference model: last granted chip and per-chip next slot.
  int         mLast;
  logic [7:0] mSlot;

  int         w;
  int         ackCycles;
  int         hits;
  logic [7:0] elig;

  job_dispatch_scheduler #(
    .NUM_CHIPS     (8),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .SysClock      (SysClock),
    .SysReset_N    (SysReset_N),
    .DispatchEnable(DispatchEnable),
    .ChipEnableMask(ChipEnableMask),
    .JobPending    (JobPending),
    .IssueStart    (IssueStart),
    .IssueChipIndex(IssueChipIndex),
    .IssueJobIndex (IssueJobIndex),
    .IssueDone     (IssueDone),
    .JobAck        (JobAck),
    .SlotSel       (SlotSel),
    .Busy          (Busy),
    .TimeoutFault  (TimeoutFault),
    .FaultClear    (FaultClear)
  );

  always #5 SysClock = ~SysClock;

  task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int modelPick(input logic [7:0] req);
    for (int k = 1; k <= 8; k++) begin
      if (req[(mLast + k) % 8]) return (mLast + k) % 8;
    end
    return -1;
  endfunction

  task automatic modelReset();
    mLast = 7;
    mSlot = 8'h00;
  endtask

  // Waits for a grant, plays the engine (done after 'delay' cycles for 'len' cycles),
  // and returns at the negedge of the mandatory IDLE gap cycle.
  // mode 1 scrambles inputs mid-job, mode 2 drops DispatchEnable mid-job.
  task automatic runJob(input int expChip, input int delay, input int len, input int mode);
    int   waitCnt;
    int   acks;
    logic [7:0] ackSeen;
    logic startWhileDone;
    waitCnt = 0;
    while (IssueStart !== 1'b1 && waitCnt < 20) begin
      @(negedge SysClock);
      waitCnt++;
    end
    checkValue("start_seen", IssueStart, 1);
    if (IssueStart !== 1'b1) return;
    checkValue("grant_chip", IssueChipIndex, expChip);
    checkValue("grant_slot", IssueJobIndex, mSlot[expChip]);
    if (mode == 1) begin
      JobPending     = 8'($urandom);
      ChipEnableMask = 8'($urandom);
      DispatchEnable = 1'($urandom);
    end else if (mode == 2) begin
      DispatchEnable = 1'b0;
    end
    acks = 0;
    ackSeen = '0;
    startWhileDone = 1'b0;
    @(negedge SysClock);
    checkValue("start_one_cycle", IssueStart, 0);
    repeat (delay) begin
      @(negedge SysClock);
      if (JobAck != 0) acks++;
      ackSeen |= JobAck;
    end
    IssueDone = 1'b1;
    mSlot[expChip] = ~mSlot[expChip];
    mLast = expChip;
    for (int i = 0; i < len; i++) begin
      @(negedge SysClock);
      if (JobAck != 0) acks++;
      ackSeen |= JobAck;
      if (IssueStart) startWhileDone = 1'b1;
      if (i == 0) checkValue("slotsel", SlotSel, mSlot);
    end
    IssueDone = 1'b0;
    @(negedge SysClock);
    if (JobAck != 0) acks++;
    checkValue("ack_pulses", acks, 1);
    checkValue("ack_onehot", ackSeen, 32'(1) << expChip);
    checkValue("no_start_in_done", startWhileDone, 0);
    checkValue("idle_gap", {IssueStart, Busy}, 0);
  endtask

  initial begin
    SysReset_N = 1'b0;
    DispatchEnable = 1'b0;
    ChipEnableMask = 8'h00;
    JobPending = 8'h00;
    IssueDone = 1'b0;
    FaultClear = 1'b0;
    modelReset();
    repeat (3) @(negedge SysClock);
    checkValue("reset_outputs",
               {IssueStart, IssueChipIndex, IssueJobIndex, JobAck, SlotSel, Busy, TimeoutFault}, 0);
    SysReset_N = 1'b1;
    @(negedge SysClock);
    checkValue("idle_after_reset",
               {IssueStart, IssueChipIndex, IssueJobIndex, JobAck, SlotSel, Busy, TimeoutFault}, 0);

    // Single request to chip 2, done 50 cycles after start for 3 cycles.
    JobPending = 8'h04; ChipEnableMask = 8'hFF; DispatchEnable = 1'b1;
    runJob(2, 50, 3, 0);
    JobPending = 8'h00;
    checkValue("single_slotsel", SlotSel, 8'h04);

    // Round-robin between chips 0 and 7 from a fresh reset.
    @(negedge SysClock);
    SysReset_N = 1'b0;
    modelReset();
    @(negedge SysClock);
    SysReset_N = 1'b1;
    JobPending = 8'h81;
    runJob(0, 4, 2, 0);
    checkValue("rr_slot0_a", SlotSel[0], 1);
    runJob(7, 2, 1, 0);
    checkValue("rr_slot0_b", SlotSel[0], 1);
    runJob(0, 6, 3, 0);
    checkValue("rr_slot0_c", SlotSel[0], 0);
    runJob(7, 1, 2, 0);
    JobPending = 8'h00;

    // Mask leaves only chip 5; enable dropped mid-issuance.
    JobPending = 8'hFF; ChipEnableMask = 8'h20; DispatchEnable = 1'b1;
    runJob(5, 10, 2, 2);
    hits = 0;
    repeat (10) begin
      @(negedge SysClock);
      if (IssueStart || Busy) hits++;
    end
    checkValue("no_start_disabled", hits, 0);
    DispatchEnable = 1'b1;
    runJob(5, 3, 2, 0);
    JobPending = 8'h00;

    // Watchdog: done never arrives.
    JobPending = 8'h08; ChipEnableMask = 8'hFF; DispatchEnable = 1'b1;
`ifdef JOB_DISPATCH_TIMEOUT_EN
    w = 0;
    while (IssueStart !== 1'b1 && w < 20) begin
      @(negedge SysClock);
      w++;
    end
    checkValue("wd_start", IssueStart, 1);
    checkValue("wd_chip", IssueChipIndex, modelPick(8'h08));
    ackCycles = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge SysClock);
      FaultClear = (i == 10);
      if (JobAck != 0) ackCycles++;
    end
    FaultClear = 1'b0;
    checkValue("wd_not_yet", TimeoutFault, 0);
    @(negedge SysClock);
    checkValue("wd_fault", {Busy, TimeoutFault}, 2'b11);
    JobPending = 8'h00;
    repeat (5) begin
      @(negedge SysClock);
      if (JobAck != 0) ackCycles++;
    end
    checkValue("wd_hold", {Busy, TimeoutFault}, 2'b11);
    FaultClear = 1'b1;
    @(negedge SysClock);
    FaultClear = 1'b0;
    checkValue("wd_cleared", {Busy, TimeoutFault}, 2'b10);
    @(negedge SysClock);
    checkValue("wd_idle", Busy, 0);
    checkValue("wd_no_ack", ackCycles, 0);
    checkValue("wd_slotsel", SlotSel, mSlot);
`else
    runJob(modelPick(8'h08), 150, 2, 0);
    JobPending = 8'h00;
    checkValue("no_fault", TimeoutFault, 0);
`endif

    // Randomized traffic against the model.
    for (int it = 0; it < 40; it++) begin
      JobPending     = 8'($urandom);
      ChipEnableMask = 8'($urandom);
      DispatchEnable = ($urandom_range(0, 3) != 0);
      elig = DispatchEnable ? (JobPending & ChipEnableMask) : 8'h00;
      if (elig != 8'h00) begin
        runJob(modelPick(elig), $urandom_range(0, 30), $urandom_range(1, 4), 1);
      end else begin
        hits = 0;
        repeat (3) begin
          @(negedge SysClock);
          if (IssueStart || Busy) hits++;
        end
        checkValue("no_grant_when_ineligible", hits, 0);
      end
    end

    // Asynchronous reset during WAIT_DONE.
    JobPending = 8'h30; ChipEnableMask = 8'hFF; DispatchEnable = 1'b1;
    w = 0;
    while (IssueStart !== 1'b1 && w < 20) begin
      @(negedge SysClock);
      w++;
    end
    checkValue("rst_start", IssueStart, 1);
    repeat (3) @(negedge SysClock);
    SysReset_N = 1'b0;
    #1;
    checkValue("rst_mid_outputs",
               {IssueStart, IssueChipIndex, IssueJobIndex, JobAck, SlotSel, Busy, TimeoutFault}, 0);
    modelReset();
    @(negedge SysClock);
    SysReset_N = 1'b1;
    runJob(4, 5, 2, 0);
    JobPending = 8'h00;

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation still running at %0t, expected finish", $time);
    $fatal(1, "timeout");
  end

endmodule
